// File: rtl/dmem_port_sched_pkg.sv
// dmem_port_sched_pkg: shared FSM encoding, requester IDs and lane constants for the datamem port scheduler
package dmem_port_sched_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  localparam logic [1:0] REQ_CORE = 2'd0;
  localparam logic [1:0] REQ_CON = 2'd1;
  localparam logic [1:0] REQ_VEC = 2'd2;
  localparam int VLANES = 4;
  localparam logic [3:0] STORE_MASK = 4'hF;
  function automatic logic [1:0] next_req(input logic [1:0] r);
    return (r == REQ_VEC) ? REQ_CORE : r + 2'd1;
  endfunction
endpackage

// File: rtl/dmem_port_sched_arb_pick.sv
// dmem_arb_pick: combinational 3-way picker returning a one-hot grant
//   req: request vector indexed by REQ_* ids, ptr: round-robin start id,
//   rr: 1 = round-robin from ptr, 0 = fixed priority con > vec > core, gnt: one-hot grant
module dmem_arb_pick
  import dmem_port_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       rr,
  output logic [2:0] gnt
);
  logic [2:0] rr_gnt;
  logic [2:0] fp_gnt;
  logic [1:0] idx;
  // Scan from the farthest candidate back to ptr so the closest requester wins.
  always_comb begin
    rr_gnt = '0;
    idx = '0;
    for (int i = 2; i >= 0; i--) begin
      idx = 2'((int'(ptr) + i) % 3);
      if (req[idx]) rr_gnt = 3'b001 << idx;
    end
  end
  assign fp_gnt = req[REQ_CON] ? 3'b001 << REQ_CON :
                  req[REQ_VEC] ? 3'b001 << REQ_VEC :
                  req[REQ_CORE] ? 3'b001 << REQ_CORE : 3'b000;
  assign gnt = rr ? rr_gnt : fp_gnt;
endmodule

// File: rtl/dmem_port_sched.sv
// dmem_port_sched: grants the single datamem port to core, con or a 4-beat vector burst
//   core_*/con_*: scalar req/we/addr/wdata in, gnt out, rvalid/rdata returned next cycle
//   vec_*: 4-lane request in, gnt/done pulse and registered per-lane load data out
//   mem_*: datamem port drive, mem_rdata has one-cycle latency
//   DMEM_SCHED_RR_EN defined: round-robin core->con->vec, else fixed priority con > vec > core
module dmem_port_sched
  import dmem_port_sched_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              core_req,
  input  logic [3:0]        core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              con_req,
  input  logic [3:0]        con_we,
  input  logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_wdata,
  output logic              con_gnt,
  output logic              con_rvalid,
  output logic [DATA_W-1:0] con_rdata,
  input  logic              vec_req,
  input  logic              vec_store,
  input  logic [ADDR_W-1:0] vec_addr0,
  input  logic [ADDR_W-1:0] vec_addr1,
  input  logic [ADDR_W-1:0] vec_addr2,
  input  logic [ADDR_W-1:0] vec_addr3,
  input  logic [DATA_W-1:0] vec_wdata0,
  input  logic [DATA_W-1:0] vec_wdata1,
  input  logic [DATA_W-1:0] vec_wdata2,
  input  logic [DATA_W-1:0] vec_wdata3,
  output logic              vec_gnt,
  output logic              vec_done,
  output logic [DATA_W-1:0] vec_rdata0,
  output logic [DATA_W-1:0] vec_rdata1,
  output logic [DATA_W-1:0] vec_rdata2,
  output logic [DATA_W-1:0] vec_rdata3,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_n;
  logic [1:0] lane, cap_lane, ptr;
  logic store, cap_v, rr;
  logic [2:0] req, gnt;
  logic [ADDR_W-1:0] l_addr [VLANES];
  logic [DATA_W-1:0] l_wdata [VLANES];
  logic [DATA_W-1:0] l_rdata [VLANES];
  // BURST owns the port outright; vector requests are only taken from IDLE.
  assign req = {vec_req & (state == IDLE), con_req, core_req} & {3{state != BURST}};
  dmem_arb_pick u_pick (.req(req), .ptr(ptr), .rr(rr), .gnt(gnt));
  assign core_gnt = gnt[REQ_CORE];
  assign con_gnt = gnt[REQ_CON];
  assign vec_gnt = gnt[REQ_VEC];
`ifdef DMEM_SCHED_RR_EN
  assign rr = 1'b1;
  always_ff @(posedge clk) begin
    if (!nrst) ptr <= REQ_CORE;
    else if (|gnt) ptr <= next_req(gnt[REQ_VEC] ? REQ_VEC : gnt[REQ_CON] ? REQ_CON : REQ_CORE);
  end
`else
  assign rr = 1'b0;
  assign ptr = REQ_CORE;
`endif
  assign state_n = (state == IDLE && vec_gnt) ? BURST :
                   (state == BURST && lane == 2'd3) ? DRAIN :
                   (state == DRAIN) ? IDLE : state;
  always_comb begin
    mem_en = 1'b1;
    mem_we = '0;
    mem_addr = core_addr;
    mem_wdata = core_wdata;
    if (state == BURST) begin
      mem_we = store ? STORE_MASK : 4'h0;
      mem_addr = l_addr[lane];
      mem_wdata = l_wdata[lane];
    end else if (con_gnt) begin
      mem_we = con_we;
      mem_addr = con_addr;
      mem_wdata = con_wdata;
    end else if (core_gnt) begin
      mem_we = core_we;
    end else begin
      mem_en = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      lane <= '0;
      store <= 1'b0;
      cap_v <= 1'b0;
      cap_lane <= '0;
      core_rvalid <= 1'b0;
      con_rvalid <= 1'b0;
      vec_done <= 1'b0;
      for (int k = 0; k < VLANES; k++) begin
        l_addr[k] <= '0;
        l_wdata[k] <= '0;
        l_rdata[k] <= '0;
      end
    end else begin
      state <= state_n;
      lane <= (state == BURST) ? lane + 2'd1 : 2'd0;
      // Load data for the lane issued this cycle lands on mem_rdata next cycle.
      cap_v <= (state == BURST) && !store;
      cap_lane <= lane;
      core_rvalid <= core_gnt && core_we == 4'h0;
      con_rvalid <= con_gnt && con_we == 4'h0;
      vec_done <= state == DRAIN;
      if (vec_gnt) begin
        store <= vec_store;
        l_addr[0] <= vec_addr0;
        l_addr[1] <= vec_addr1;
        l_addr[2] <= vec_addr2;
        l_addr[3] <= vec_addr3;
        l_wdata[0] <= vec_wdata0;
        l_wdata[1] <= vec_wdata1;
        l_wdata[2] <= vec_wdata2;
        l_wdata[3] <= vec_wdata3;
      end
      if (cap_v) l_rdata[cap_lane] <= mem_rdata;
    end
  end
  assign core_rdata = core_rvalid ? mem_rdata : '0;
  assign con_rdata = con_rvalid ? mem_rdata : '0;
  assign vec_rdata0 = l_rdata[0];
  assign vec_rdata1 = l_rdata[1];
  assign vec_rdata2 = l_rdata[2];
  assign vec_rdata3 = l_rdata[3];
endmodule

// File: tb/tb_dmem_port_sched.sv
// tb_dmem_port_sched: scoreboard bench for dmem_port_sched with a behavioural datamem
module tb_dmem_port_sched;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic core_req = 1'b0, con_req = 1'b0, vec_req = 1'b0, vec_store = 1'b0;
  logic [3:0] core_we = '0, con_we = '0;
  logic [11:0] core_addr = '0, con_addr = '0;
  logic [31:0] core_wdata = '0, con_wdata = '0;
  logic [11:0] vec_addr0 = '0, vec_addr1 = '0, vec_addr2 = '0, vec_addr3 = '0;
  logic [31:0] vec_wdata0 = '0, vec_wdata1 = '0, vec_wdata2 = '0, vec_wdata3 = '0;
  logic core_gnt, core_rvalid, con_gnt, con_rvalid, vec_gnt, vec_done, mem_en;
  logic [31:0] core_rdata, con_rdata, vec_rdata0, vec_rdata1, vec_rdata2, vec_rdata3;
  logic [3:0] mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:4095];
  logic [31:0] em [0:4095];
  logic [31:0] q_core [$];
  logic [31:0] q_con [$];
  logic [127:0] q_vec [$];
  logic [127:0] last_vec = '0;
  int n_run = 0, n_fail = 0;

  dmem_port_sched dut (
    .clk(clk), .nrst(nrst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .con_req(con_req), .con_we(con_we), .con_addr(con_addr), .con_wdata(con_wdata),
    .con_gnt(con_gnt), .con_rvalid(con_rvalid), .con_rdata(con_rdata),
    .vec_req(vec_req), .vec_store(vec_store),
    .vec_addr0(vec_addr0), .vec_addr1(vec_addr1), .vec_addr2(vec_addr2), .vec_addr3(vec_addr3),
    .vec_wdata0(vec_wdata0), .vec_wdata1(vec_wdata1), .vec_wdata2(vec_wdata2), .vec_wdata3(vec_wdata3),
    .vec_gnt(vec_gnt), .vec_done(vec_done),
    .vec_rdata0(vec_rdata0), .vec_rdata1(vec_rdata1), .vec_rdata2(vec_rdata2), .vec_rdata3(vec_rdata3),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (core_rvalid) begin
        if (q_core.size() == 0) chk("core_rvalid_spurious", core_rvalid, 0);
        else chk("core_rdata", core_rdata, q_core.pop_front());
      end
      if (con_rvalid) begin
        if (q_con.size() == 0) chk("con_rvalid_spurious", con_rvalid, 0);
        else chk("con_rdata", con_rdata, q_con.pop_front());
      end
      if (vec_done) begin
        if (q_vec.size() == 0) chk("vec_done_spurious", vec_done, 0);
        else chk("vec_rdata", {vec_rdata3, vec_rdata2, vec_rdata1, vec_rdata0}, q_vec.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all;
    core_req = 1'b0;
    con_req = 1'b0;
    vec_req = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {core_gnt, con_gnt, vec_gnt, core_rvalid, con_rvalid, vec_done, mem_en, mem_we}, 0);
    chk({tag, "_rdata"}, {core_rdata, con_rdata}, 0);
    chk({tag, "_vrdata"}, {vec_rdata3, vec_rdata2, vec_rdata1, vec_rdata0}, 0);
  endtask

  task automatic do_reset;
    drop_all();
    nrst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk_reset_outs("reset");
    last_vec = '0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic wait_gnt(input int w, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((w == 0 && core_gnt) || (w == 1 && con_gnt) || (w == 2 && vec_gnt)) ok = 1'b1;
      else tick();
    end
    if (!ok) chk(tag, {vec_gnt, con_gnt, core_gnt}, 3'b001 << w);
  endtask

  task automatic set_vec(input bit st, input logic [11:0] base, input logic [31:0] db);
    vec_req = 1'b1;
    vec_store = st;
    vec_addr0 = base;
    vec_addr1 = base + 12'd1;
    vec_addr2 = base + 12'd2;
    vec_addr3 = base + 12'd3;
    vec_wdata0 = db;
    vec_wdata1 = db + 32'd1;
    vec_wdata2 = db + 32'd2;
    vec_wdata3 = db + 32'd3;
  endtask

  task automatic sgl(input int w, input logic [3:0] we, input logic [11:0] addr, input logic [31:0] wdata);
    bit ok;
    if (w == 0) begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end else begin
      con_req = 1'b1; con_we = we; con_addr = addr; con_wdata = wdata;
    end
    wait_gnt(w, (w == 0) ? "core_gnt_timeout" : "con_gnt_timeout", ok);
    if (ok) begin
      chk("sgl_onehot", {vec_gnt, con_gnt, core_gnt}, 3'b001 << w);
      chk("sgl_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, we, addr, wdata});
      if (we != 4'h0) em[addr] = wdata;
      else if (w == 0) q_core.push_back(em[addr]);
      else q_con.push_back(em[addr]);
    end
    tick();
    core_req = 1'b0;
    con_req = 1'b0;
    @(negedge clk);
    chk("sgl_rvalid", (w == 0) ? core_rvalid : con_rvalid, ok && we == 4'h0);
    tick();
  endtask

  task automatic vacc(input bit st, input logic [11:0] base, input logic [31:0] db, input bit hold);
    bit ok;
    logic [127:0] exp;
    set_vec(st, base, db);
    wait_gnt(2, "vec_gnt_timeout", ok);
    if (ok) begin
      chk("vec_grant_no_issue", mem_en, 0);
      if (st) begin
        for (int k = 0; k < 4; k++) em[base + 12'(k)] = db + 32'(k);
        exp = last_vec;
      end else begin
        exp = {em[base + 12'd3], em[base + 12'd2], em[base + 12'd1], em[base]};
        last_vec = exp;
      end
      q_vec.push_back(exp);
      tick();
      vec_req = 1'b0;
      if (hold) begin
        core_req = 1'b1; core_we = 4'h0; core_addr = 12'h010;
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("vec_beat", {mem_en, mem_we, mem_addr}, {1'b1, st ? 4'hF : 4'h0, base + 12'(k)});
        if (st) chk("vec_beat_wdata", mem_wdata, db + 32'(k));
        chk("vec_beat_gnts", {vec_gnt, con_gnt, core_gnt}, 0);
        tick();
      end
      @(negedge clk);
      chk("vec_drain_done", vec_done, 0);
      chk("vec_drain_gnts", {vec_gnt, con_gnt, core_gnt}, hold ? 3'b001 : 3'b000);
      if (hold) q_core.push_back(em[12'h010]);
      tick();
      core_req = 1'b0;
      @(negedge clk);
      chk("vec_done_pulse", vec_done, 1);
    end
    vec_req = 1'b0;
    tick();
  endtask

  task automatic rst_mid;
    bit ok;
    set_vec(1'b1, 12'h050, 32'hB0);
    wait_gnt(2, "vec_gnt_timeout", ok);
    tick();
    vec_req = 1'b0;
    @(negedge clk);
    chk("rst_lane0", {mem_en, mem_we, mem_addr}, {1'b1, 4'hF, 12'h050});
    tick();
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_lane1", {mem_en, mem_we, mem_addr}, {1'b1, 4'hF, 12'h051});
    tick();
    nrst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    em[12'h050] = 32'hB0;
    em[12'h051] = 32'hB1;
    last_vec = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      chk("midrst_no_done", vec_done, 0);
    end
    tick();
  endtask

  task automatic arb;
    logic [1:0] tbl [10];
`ifdef DMEM_SCHED_RR_EN
    tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
`else
    tbl = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    core_req = 1'b1; core_we = 4'h0; core_addr = 12'h010;
    con_req = 1'b1; con_we = 4'h0; con_addr = 12'h030;
    set_vec(1'b0, 12'h020, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arb_gnt", {vec_gnt, con_gnt, core_gnt}, (tbl[i] == 2'd0) ? 3'b000 : 3'b001 << (tbl[i] - 2'd1));
      if (tbl[i] == 2'd1) q_core.push_back(em[12'h010]);
      if (tbl[i] == 2'd2) q_con.push_back(em[12'h030]);
      if (tbl[i] == 2'd3) begin
        last_vec = {em[12'h023], em[12'h022], em[12'h021], em[12'h020]};
        q_vec.push_back(last_vec);
      end
      tick();
    end
    drop_all();
  endtask

  initial begin
    do_reset();
    sgl(0, 4'hF, 12'h010, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) sgl(0, 4'hF, 12'h020 + 12'(k), 32'(k + 1));
    sgl(1, 4'hF, 12'h030, 32'h12345678);
    sgl(0, 4'hF, 12'h052, 32'h0);
    sgl(0, 4'hF, 12'h053, 32'h0);
    sgl(0, 4'h0, 12'h010, 32'h0);
    sgl(1, 4'h0, 12'h030, 32'h0);
    vacc(1'b0, 12'h020, 32'h0, 1'b0);
    vacc(1'b1, 12'h040, 32'hA0, 1'b1);
    for (int k = 0; k < 4; k++) sgl(0, 4'h0, 12'h040 + 12'(k), 32'h0);
    rst_mid();
    for (int k = 0; k < 4; k++) sgl(0, 4'h0, 12'h050 + 12'(k), 32'h0);
    do_reset();
    arb();
    repeat (12) tick();
    chk("q_core_drained", 128'(q_core.size()), 0);
    chk("q_con_drained", 128'(q_con.size()), 0);
    chk("q_vec_drained", 128'(q_vec.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
